// File: rtl/pll_clk_checker.sv
// PLL output clock checker: counts mon_clk rising edges over fixed refclk gate
// windows and qualifies lock plus frequency before releasing the PLL-domain reset.
module pll_clk_checker #(
   parameter int unsigned GATE_CYCLES  = 5000,
   parameter int unsigned EXP_EDGES    = 80,
   parameter int unsigned TOL          = 2,
   parameter int unsigned GOOD_WINDOWS = 4
) (
   input  logic        refclk,
   input  logic        rst,
   input  logic        pll_locked,
   input  logic        mon_clk,
   input  logic        clear,
   output logic        clk_ok,
   output logic        rst_out_n,
   output logic        fault,
   output logic [15:0] edge_count
);

   localparam int unsigned GCW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int unsigned GDW = $clog2(GOOD_WINDOWS + 1);
   localparam logic [GCW-1:0] GATE_LAST = GCW'(GATE_CYCLES - 1);
   localparam logic [GDW-1:0] GOOD_MAX  = GDW'(GOOD_WINDOWS);
   localparam logic [GDW-1:0] GOOD_PREV = GDW'(GOOD_WINDOWS - 1);
   // Lower bound clamps at zero so a TOL wider than EXP_EDGES cannot wrap.
   localparam int unsigned LO_EDGES = (TOL > EXP_EDGES) ? 0 : EXP_EDGES - TOL;
   localparam int unsigned HI_EDGES = EXP_EDGES + TOL;

   typedef enum logic [1:0] {WAIT_LOCK, MEASURE, CHECK, RUN} state_t;

   state_t           state, state_nx;
   logic             lock_s1, lock_s2;
   logic             mon_s1, mon_s2, mon_s3;
   logic [GCW-1:0]   gate_cnt;
   logic [15:0]      edge_cnt, edge_total;
   logic [GDW-1:0]   good_cnt;
   logic             ok_q;
   logic             edge_hit, win_last, in_range, running;
   logic             counting, win_end, good_inc, good_clr, ok_set, ok_clr, fault_set;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchronizer chain.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         lock_s1 <= 1'b0;
         lock_s2 <= 1'b0;
         mon_s1  <= 1'b0;
         mon_s2  <= 1'b0;
         mon_s3  <= 1'b0;
      end else begin
         lock_s1 <= pll_locked;
         lock_s2 <= lock_s1;
         mon_s1  <= mon_clk;
         mon_s2  <= mon_s1;
         mon_s3  <= mon_s2;
      end
   end

   assign edge_hit   = mon_s2 & ~mon_s3;
   assign win_last   = (gate_cnt == GATE_LAST);
   assign edge_total = (&edge_cnt) ? edge_cnt : edge_cnt + 16'(edge_hit);
   assign in_range   = (32'(edge_count) >= LO_EDGES) && (32'(edge_count) <= HI_EDGES);
   // A saturated good counter means the clock was already declared good, so a
   // CHECK reached from RUN still counts as a running clock for fault purposes.
   assign running    = (state == RUN) || ((state == CHECK) && (good_cnt == GOOD_MAX));

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) state <= WAIT_LOCK;
      else      state <= state_nx;
   end

   // NOTE: every output of this block gets a default first so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx  = state;
      counting  = 1'b0;
      win_end   = 1'b0;
      good_inc  = 1'b0;
      good_clr  = 1'b0;
      ok_set    = 1'b0;
      ok_clr    = 1'b0;
      fault_set = 1'b0;
      if (!lock_s2) begin
         state_nx  = WAIT_LOCK;
         good_clr  = 1'b1;
         ok_clr    = 1'b1;
         fault_set = running;
      end else begin
         unique case (state)
            WAIT_LOCK: state_nx = MEASURE;
            MEASURE, RUN: begin
               counting = 1'b1;
               ok_set   = (state == RUN);
               if (win_last) begin
                  win_end  = 1'b1;
                  state_nx = CHECK;
               end
            end
            CHECK: begin
               if (in_range) begin
                  good_inc = 1'b1;
                  state_nx = (good_cnt >= GOOD_PREV) ? RUN : MEASURE;
               end else begin
                  good_clr  = 1'b1;
                  ok_clr    = 1'b1;
                  fault_set = running;
                  state_nx  = MEASURE;
               end
            end
            default: state_nx = WAIT_LOCK;
         endcase
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         edge_count <= '0;
         good_cnt   <= '0;
         ok_q       <= 1'b0;
         fault      <= 1'b0;
      end else begin
         if (counting && !win_end) begin
            gate_cnt <= gate_cnt + GCW'(1);
            edge_cnt <= edge_total;
         end else begin
            gate_cnt <= '0;
            edge_cnt <= '0;
         end
         if (win_end) edge_count <= edge_total;
         if (good_clr)                             good_cnt <= '0;
         else if (good_inc && good_cnt != GOOD_MAX) good_cnt <= good_cnt + GDW'(1);
         if (ok_clr)      ok_q <= 1'b0;
         else if (ok_set) ok_q <= 1'b1;
         // A new fault event outranks a coincident clear.
         if (fault_set)  fault <= 1'b1;
         else if (clear) fault <= 1'b0;
      end
   end

   assign clk_ok    = ok_q;
   assign rst_out_n = ok_q;

endmodule

// File: tb/tb_pll_clk_checker.sv
// Randomized scoreboard bench for pll_clk_checker: a window-level reference model
// predicts every output change and the cycle it appears on.
module tb_pll_clk_checker;

   localparam int G   = 40;
   localparam int EXP = 5;
   localparam int TOL = 1;
   localparam int GW  = 3;

   logic        refclk = 1'b0;
   logic        rst = 1'b1;
   logic        pll_locked = 1'b0;
   logic        mon_clk = 1'b0;
   logic        clear = 1'b0;
   logic        clk_ok, rst_out_n, fault;
   logic [15:0] edge_count;

   pll_clk_checker #(
      .GATE_CYCLES (G),
      .EXP_EDGES   (EXP),
      .TOL         (TOL),
      .GOOD_WINDOWS(GW)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .pll_locked(pll_locked),
      .mon_clk   (mon_clk),
      .clear     (clear),
      .clk_ok    (clk_ok),
      .rst_out_n (rst_out_n),
      .fault     (fault),
      .edge_count(edge_count)
   );

   always #5 refclk = ~refclk;

   typedef struct packed {
      logic [31:0] cyc;
      logic [18:0] val;
   } exp_t;

   typedef struct {
      int len;
      int per;
      bit lock;
      int clr;
   } seg_t;

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb_q[$];
   seg_t plan[$];
   bit   lock_hist[$];
   bit   mon_hist[$];

   // Reference model: sessions of fixed-length windows separated by a judging cycle.
   typedef enum {IDLE, COUNTING, JUDGING} phase_t;
   phase_t      ph;
   int          pos, cnt, good;
   bit          declared;
   logic [15:0] x_ec;
   bit          x_ok, x_fault;
   logic [18:0] x_prev;

   bit          active = 1'b0;
   int          mcyc;
   logic [18:0] mprev, mcur;
   exp_t        me;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h required %h", name, got, want);
   endtask

   // Monitor: whenever the DUT presents a changed output (or one is due), pop and compare.
   initial forever begin
      @(posedge refclk);
      #2;
      if (active) begin
         mcyc++;
         mcur = {clk_ok, rst_out_n, fault, edge_count};
         if (mcur !== mprev || (sb_q.size() > 0 && sb_q[0].cyc == 32'(mcyc))) begin
            if (sb_q.size() == 0) begin
               check("unexpected_change", {32'(mcyc), 13'b0, mcur}, {32'(mcyc), 13'b0, mprev});
            end else begin
               me = sb_q.pop_front();
               check("output_change", {32'(mcyc), 13'b0, mcur}, {me.cyc, 13'b0, me.val});
            end
            mprev = mcur;
         end
      end
   end

   function automatic bit in_window_range(input int ec);
      return (ec >= EXP - TOL) && (ec <= EXP + TOL);
   endfunction

   task automatic model_step(input int n, input bit clr);
      bit          lk, ed, ev;
      logic [18:0] nv;
      lk = (n >= 2) ? lock_hist[n-2] : 1'b0;
      ed = (n >= 2) ? (mon_hist[n-2] && !((n >= 3) ? mon_hist[n-3] : 1'b0)) : 1'b0;
      ev = 1'b0;
      if (!lk) begin
         ev = declared;
         declared = 1'b0;
         good = 0;
         ph = IDLE;
         x_ok = 1'b0;
      end else begin
         case (ph)
            IDLE: begin
               ph = COUNTING;
               pos = 0;
               cnt = 0;
            end
            COUNTING: begin
               if (declared) x_ok = 1'b1;
               cnt += int'(ed);
               if (pos == G - 1) begin
                  x_ec = 16'(cnt);
                  ph = JUDGING;
               end else begin
                  pos++;
               end
            end
            JUDGING: begin
               if (in_window_range(int'(x_ec))) begin
                  good++;
                  if (good >= GW) declared = 1'b1;
               end else begin
                  ev = declared;
                  declared = 1'b0;
                  good = 0;
                  x_ok = 1'b0;
               end
               ph = COUNTING;
               pos = 0;
               cnt = 0;
            end
            default: ph = IDLE;
         endcase
      end
      if (ev)       x_fault = 1'b1;
      else if (clr) x_fault = 1'b0;
      nv = {x_ok, x_ok, x_fault, x_ec};
      if (nv !== x_prev) sb_q.push_back('{cyc: 32'(n + 1), val: nv});
      x_prev = nv;
   endtask

   task automatic add_seg(input int len, input int per, input bit lock, input int clr);
      seg_t s;
      s.len = len;
      s.per = per;
      s.lock = lock;
      s.clr = clr;
      plan.push_back(s);
   endtask

   // Asynchronous reset at an arbitrary point, then play the current plan.
   task automatic run_episode();
      int n, phs;
      bit first, m, c;
      @(posedge refclk);
      #3;
      active = 1'b0;
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      rst = 1'b0;
      #1;
      check("reset_outputs", 64'({clk_ok, rst_out_n, fault, edge_count}), 64'd0);
      repeat (2) @(posedge refclk);
      @(negedge refclk);
      rst = 1'b1;
      sb_q.delete();
      lock_hist.delete();
      mon_hist.delete();
      ph = IDLE; pos = 0; cnt = 0; good = 0; declared = 1'b0;
      x_ec = '0; x_ok = 1'b0; x_fault = 1'b0; x_prev = '0;
      mcyc = 0; mprev = '0;
      active = 1'b1;
      n = 0;
      first = 1'b1;
      foreach (plan[i]) begin
         phs = (plan[i].per > 0) ? int'($urandom % plan[i].per) : 0;
         for (int k = 0; k < plan[i].len; k++) begin
            if (!first) @(negedge refclk);
            first = 1'b0;
            if (plan[i].per == 0) m = 1'b0;
            else begin
               m = (phs < plan[i].per / 2);
               phs = (phs + 1) % plan[i].per;
            end
            case (plan[i].clr)
               1: c = (k == 0);
               2: c = 1'b1;
               3: c = ($urandom % 16 == 0);
               default: c = 1'b0;
            endcase
            pll_locked = plan[i].lock;
            mon_clk = m;
            clear = c;
            lock_hist.push_back(plan[i].lock);
            mon_hist.push_back(m);
            model_step(n, c);
            n++;
         end
      end
      plan.delete();
   endtask

   int per_tab[8] = '{0, 4, 6, 7, 8, 8, 10, 12};

   initial begin
      // Nominal lock, stopped clock in RUN, lone clear, lock loss with clear held, relock.
      add_seg(200, 8, 1'b1, 0);
      add_seg(90, 0, 1'b1, 0);
      add_seg(5, 0, 1'b1, 1);
      add_seg(200, 8, 1'b1, 0);
      add_seg(30, 8, 1'b0, 2);
      add_seg(200, 8, 1'b1, 0);
      run_episode();
      // Wrong frequency: twice the expected edge rate never qualifies.
      add_seg(250, 4, 1'b1, 0);
      run_episode();
      // Lower range boundary (4 edges) qualifies, then a marginal 6-7 edge rate.
      add_seg(250, 10, 1'b1, 0);
      add_seg(150, 6, 1'b1, 3);
      run_episode();
      // Randomized sequences, each cut short by a reset at an arbitrary cycle.
      repeat (6) begin
         repeat (8) begin
            add_seg(20 + int'($urandom % 180), per_tab[$urandom % 8],
                    ($urandom % 6) != 0, int'($urandom % 4));
         end
         run_episode();
      end
      @(posedge refclk);
      #3;
      active = 1'b0;
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
